// File: rtl/syrk_stream.sv
// Streaming symmetric rank-K update: loads alpha, beta, A (N x K) and C (N x N),
// then updates the selected triangle of C with alpha*A*A^T + beta*C and streams C out.
module syrk_stream #(
  parameter int DATA_W = 32,
  parameter int N      = 4,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uplo,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, LD_ALPHA, LD_BETA, LD_A, LD_C, COMPUTE, OUTPUT
  } state_t;

  localparam int NK  = N * K;
  localparam int NN  = N * N;
  localparam int AW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int CIW = (NN > 1) ? $clog2(NN) : 1;
  localparam int CW  = 32;

  state_t            state_q, state_d;
  logic              uplo_q, uplo_d;
  logic [DATA_W-1:0] alpha_q, alpha_d, beta_q, beta_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic              done_q, done_d;

  // A and C storage is never reset; every word is reloaded before it is read.
  logic [DATA_W-1:0] aMem [NK];
  logic [DATA_W-1:0] cMem [NN];

  logic              aWe, cWe;
  logic [AW-1:0]     aWrIdx, aRowI, aRowJ;
  logic [CIW-1:0]    cWrIdx, cElem, outIdx;
  logic [DATA_W-1:0] cWrData, prod;

  assign aRowI  = AW'(i_q * K + k_q);
  assign aRowJ  = AW'(j_q * K + k_q);
  assign cElem  = CIW'(i_q * N + j_q);
  assign outIdx = CIW'(cnt_q);
  assign prod   = aMem[aRowI] * aMem[aRowJ];

  assign in_ready  = (state_q == LD_ALPHA) || (state_q == LD_BETA) ||
                     (state_q == LD_A) || (state_q == LD_C);
  assign out_valid = (state_q == OUTPUT);
  assign out_data  = (state_q == OUTPUT) ? cMem[outIdx] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    uplo_d  = uplo_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    aWe     = 1'b0;
    cWe     = 1'b0;
    aWrIdx  = AW'(cnt_q);
    cWrIdx  = CIW'(cnt_q);
    cWrData = in_data;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LD_ALPHA;
          uplo_d  = uplo;
          cnt_d   = '0;
        end
      end
      LD_ALPHA: begin
        if (in_valid) begin
          alpha_d = in_data;
          state_d = LD_BETA;
        end
      end
      LD_BETA: begin
        if (in_valid) begin
          beta_d  = in_data;
          state_d = LD_A;
          cnt_d   = '0;
        end
      end
      LD_A: begin
        if (in_valid) begin
          aWe = 1'b1;
          if (cnt_q == CW'(NK - 1)) begin
            cnt_d   = '0;
            state_d = LD_C;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LD_C: begin
        if (in_valid) begin
          cWe = 1'b1;
          if (cnt_q == CW'(NN - 1)) begin
            cnt_d   = '0;
            state_d = COMPUTE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        // k runs 0..K-1 accumulating, then one extra step (k == K) writes the element back.
        if (k_q != CW'(K)) begin
          acc_d = acc_q + prod;
          k_d   = k_q + CW'(1);
        end else begin
          cWe     = 1'b1;
          cWrIdx  = cElem;
          cWrData = alpha_q * acc_q + beta_q * cMem[cElem];
          acc_d   = '0;
          k_d     = '0;
          if (i_q == CW'(N - 1) && j_q == CW'(N - 1)) begin
            state_d = OUTPUT;
            cnt_d   = '0;
          end else if (uplo_q) begin
            if (j_q == CW'(N - 1)) begin
              i_d = i_q + CW'(1);
              j_d = i_q + CW'(1);
            end else begin
              j_d = j_q + CW'(1);
            end
          end else begin
            if (j_q == i_q) begin
              i_d = i_q + CW'(1);
              j_d = '0;
            end else begin
              j_d = j_q + CW'(1);
            end
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (cnt_q == CW'(NN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      uplo_q  <= 1'b0;
      alpha_q <= '0;
      beta_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      uplo_q  <= uplo_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aWe && rst) aMem[aWrIdx] <= in_data;
    if (cWe && rst) cMem[cWrIdx] <= cWrData;
  end

endmodule
